// File: rtl/dmem_resp_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_resp_if
// Description : Request/response bundle between a core load/store unit and
//               the dmem_resp data-memory responder.
//               master modport : core side (drives requests)
//               slave modport  : memory side (drives ready and responses)
//   req_valid  - request present          req_ready  - responder idle
//   req_we     - 1 store / 0 load         req_funct3 - RV32I size/sign code
//   req_addr   - byte address             req_wdata  - right-aligned store data
//   resp_valid - one-cycle completion     resp_rdata - extended load data
//   resp_err   - request faulted (qualified by resp_valid)
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_resp_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface
`default_nettype wire

// File: rtl/dmem_resp.sv
`default_nettype none
// ============================================================================
// Module      : dmem_resp
// Description : Fixed-latency RV32I data-memory responder. Accepts one
//               load/store at a time, waits LATENCY cycles, then performs
//               the access against an internal word array and returns a
//               single-cycle response with sign/zero-extended load data or
//               an error flag for out-of-range, misaligned or illegal ops.
// Ports       : clk  - clock, all state updates on rising edge
//               rst  - asynchronous active-high reset
//               bus  - dmem_resp_if.slave (request/response bundle)
// Parameters  : DEPTH_WORDS - number of 32-bit words in the array
//               LATENCY     - wait cycles between acceptance and response
//                             (0..15)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_resp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  wire logic       clk,
    input  wire logic       rst,
    dmem_resp_if.slave      bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int          c_ADDR_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] c_DEPTH32  = 32'(DEPTH_WORDS);
    localparam logic [3:0]  c_CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam bit          c_ZERO_LAT = (LATENCY == 0);

    localparam logic [1:0]  c_ST_IDLE  = 2'd0;
    localparam logic [1:0]  c_ST_WAIT  = 2'd1;
    localparam logic [1:0]  c_ST_RESP  = 2'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    logic [31:0] r_mem [DEPTH_WORDS];

    // ------------------------------------------------------------------------
    // Handshake and operand selection
    // ------------------------------------------------------------------------
    logic        w_idle;
    logic        w_accept;
    logic        w_enter_resp;
    logic        w_we;
    logic [2:0]  w_funct3;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;

    assign w_idle   = (r_state == c_ST_IDLE);
    assign w_accept = w_idle && bus.req_valid;

    // With zero latency the access happens on the acceptance edge itself, so
    // the live request fields must be used; otherwise the captured copy is.
    assign w_we     = w_idle ? bus.req_we     : r_we;
    assign w_funct3 = w_idle ? bus.req_funct3 : r_funct3;
    assign w_addr   = w_idle ? bus.req_addr   : r_addr;
    assign w_wdata  = w_idle ? bus.req_wdata  : r_wdata;

    assign w_enter_resp = c_ZERO_LAT ? w_accept
                                     : ((r_state == c_ST_WAIT) && (r_cnt == 4'd0));

    // ------------------------------------------------------------------------
    // Address decode and fault detection
    // ------------------------------------------------------------------------
    logic [29:0]         w_idx;
    logic [c_ADDR_W-1:0] w_mem_idx;
    logic                w_range_err;
    logic                w_align_err;
    logic                w_f3_err;
    logic                w_err;

    assign w_idx       = w_addr[31:2];
    assign w_mem_idx   = w_idx[c_ADDR_W-1:0];
    assign w_range_err = ({2'b00, w_idx} >= c_DEPTH32);

    always_comb begin
        w_align_err = 1'b0;
        case (w_funct3[1:0])
            2'b01:   w_align_err = w_addr[0];
            2'b10:   w_align_err = (w_addr[1:0] != 2'b00);
            default: w_align_err = 1'b0;
        endcase
    end

    always_comb begin
        w_f3_err = 1'b0;
        if (w_we) begin
            w_f3_err = (w_funct3 >= 3'b011);
        end else begin
            w_f3_err = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) ||
                       (w_funct3 == 3'b111);
        end
    end

    assign w_err = w_range_err || w_align_err || w_f3_err;

    // ------------------------------------------------------------------------
    // Load path: lane selection and extension
    // ------------------------------------------------------------------------
    logic [31:0] w_rd_word;
    logic [7:0]  w_lane_byte;
    logic [15:0] w_lane_half;
    logic [31:0] w_load_data;

    // Out-of-range indices read an arbitrary word; the result is discarded
    // because w_err forces the response data to zero.
    assign w_rd_word = r_mem[w_mem_idx];

    always_comb begin
        w_lane_byte = 8'h00;
        case (w_addr[1:0])
            2'd0:    w_lane_byte = w_rd_word[7:0];
            2'd1:    w_lane_byte = w_rd_word[15:8];
            2'd2:    w_lane_byte = w_rd_word[23:16];
            default: w_lane_byte = w_rd_word[31:24];
        endcase
        w_lane_half = w_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];
    end

    always_comb begin
        w_load_data = 32'h0000_0000;
        if (!w_err && !w_we) begin
            case (w_funct3)
                3'b000:  w_load_data = {{24{w_lane_byte[7]}}, w_lane_byte};
                3'b100:  w_load_data = {24'h00_0000, w_lane_byte};
                3'b001:  w_load_data = {{16{w_lane_half[15]}}, w_lane_half};
                3'b101:  w_load_data = {16'h0000, w_lane_half};
                3'b010:  w_load_data = w_rd_word;
                default: w_load_data = 32'h0000_0000;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Store path: byte enables and lane-replicated write data
    // ------------------------------------------------------------------------
    logic [3:0]  w_be;
    logic [31:0] w_wd_lanes;
    logic        w_commit;

    // Replicating the narrow store data across every lane lets the byte
    // enables alone decide which lanes change.
    always_comb begin
        w_be       = 4'b0000;
        w_wd_lanes = 32'h0000_0000;
        case (w_funct3[1:0])
            2'b00: begin
                w_be       = 4'b0001 << w_addr[1:0];
                w_wd_lanes = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_be       = 4'b0011 << w_addr[1:0];
                w_wd_lanes = {2{w_wdata[15:0]}};
            end
            2'b10: begin
                w_be       = 4'b1111;
                w_wd_lanes = w_wdata;
            end
            default: begin
                w_be       = 4'b0000;
                w_wd_lanes = 32'h0000_0000;
            end
        endcase
    end

    assign w_commit = w_enter_resp && w_we && !w_err;

    // The array is never reset; a reset asserted at the commit edge aborts
    // the in-flight store, so the write is also gated by rst.
    always_ff @(posedge clk) begin
        if (!rst && w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_mem_idx][8*b +: 8] <= w_wd_lanes[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM
    // resp_valid is registered on the edge leaving RESP, so the response
    // cycle coincides with the first IDLE cycle and back-to-back requests
    // are accepted every LATENCY+2 cycles.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= 4'd0;
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr       <= 32'h0000_0000;
            r_wdata      <= 32'h0000_0000;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0000_0000;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_we     <= bus.req_we;
                        r_funct3 <= bus.req_funct3;
                        r_addr   <= bus.req_addr;
                        r_wdata  <= bus.req_wdata;
                        if (c_ZERO_LAT) begin
                            r_state <= c_ST_RESP;
                        end else begin
                            r_state <= c_ST_WAIT;
                            r_cnt   <= c_CNT_INIT;
                        end
                    end
                end
                c_ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= c_ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_ST_RESP: begin
                    r_state      <= c_ST_IDLE;
                    r_resp_valid <= 1'b1;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase

            // Response payload is captured with the access and then held
            // until the next access completes.
            if (w_enter_resp) begin
                r_resp_rdata <= w_load_data;
                r_resp_err   <= w_err;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.req_ready  = w_idle;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;

endmodule
`default_nettype wire
